// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a valid/ready handshake on both sides.
// Decodes ALU control, register indices, immediates and datapath flags, and counts illegal encodings.
module rv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int EN_SHIFT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  instr_out,
  output logic [3:0]       alu_ctrl,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic             reg_write,
  output logic             alu_src_imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam bit         SHIFT_OK  = (EN_SHIFT != 0);

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            alu_src_imm;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       accept;
  ctrl_t      dec;
  ctrl_t      ctrl_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every decode output gets a default before the case so no path leaves a latch.
    dec   = '0;
    legal = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_ZERO) begin
          unique case (funct3)
            3'b000: begin legal = 1'b1;     dec.alu_ctrl = 4'b0010; end
            3'b111: begin legal = 1'b1;     dec.alu_ctrl = 4'b0000; end
            3'b110: begin legal = 1'b1;     dec.alu_ctrl = 4'b0001; end
            3'b100: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b0011; end
            3'b001: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b0100; end
            3'b101: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b0101; end
            3'b010: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b1011; end
            3'b011: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b1100; end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal        = 1'b1;
            dec.alu_ctrl = 4'b0110;
          end else if (funct3 == 3'b101) begin
            legal        = SHIFT_OK;
            dec.alu_ctrl = 4'b0111;
          end
        end
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(XLEN-12){instr[31]}}, instr[31:20]};
        unique case (funct3)
          3'b000: begin legal = 1'b1;     dec.alu_ctrl = 4'b1010; end
          3'b111: begin legal = 1'b1;     dec.alu_ctrl = 4'b1000; end
          3'b110: begin legal = 1'b1;     dec.alu_ctrl = 4'b1001; end
          3'b100: begin legal = SHIFT_OK; dec.alu_ctrl = 4'b1101; end
          3'b001: begin
            legal        = SHIFT_OK && (funct7 == F7_ZERO);
            dec.alu_ctrl = 4'b1110;
          end
          // instr[30] tells the ALU whether the right shift is arithmetic.
          3'b101: begin
            legal        = SHIFT_OK && (funct7 == F7_ZERO || funct7 == F7_ALT);
            dec.alu_ctrl = 4'b1111;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        legal           = (funct3 == 3'b010);
        dec.alu_ctrl    = 4'b0010;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        legal           = (funct3 == 3'b010);
        dec.alu_ctrl    = 4'b0010;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        legal        = (funct3 == 3'b000);
        dec.alu_ctrl = 4'b0110;
        dec.branch   = 1'b1;
        dec.imm      = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: legal = 1'b0;
    endcase

    // Unsupported encodings carry no control or immediate, only the illegal flag.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid     <= 1'b0;
      instr_out     <= '0;
      rd            <= '0;
      rs1           <= '0;
      rs2           <= '0;
      ctrl_q        <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      instr_out <= instr;
      rd        <= instr[11:7];
      rs1       <= instr[19:15];
      rs2       <= instr[24:20];
      ctrl_q    <= dec;
      if (dec.illegal && (illegal_count != '1))
        illegal_count <= illegal_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_ctrl    = ctrl_q.alu_ctrl;
  assign imm         = ctrl_q.imm;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: a table-driven instruction model predicts every cycle,
// with a shift-enabled and a shift-disabled (narrow counter) instance driven side by side.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid;
  logic [31:0] instr_out, imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd, rs1, rs2;
  logic        reg_write, alu_src_imm, mem_read, mem_write, branch, illegal;
  logic [15:0] illegal_count;

  logic        ns_in_ready, ns_out_valid;
  logic [31:0] ns_instr_out, ns_imm;
  logic [3:0]  ns_alu_ctrl;
  logic [4:0]  ns_rd, ns_rs1, ns_rs2;
  logic        ns_reg_write, ns_alu_src_imm, ns_mem_read, ns_mem_write, ns_branch, ns_illegal;
  logic [2:0]  ns_illegal_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .EN_SHIFT(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .alu_ctrl(alu_ctrl),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  rv_decode_stage #(.XLEN(32), .EN_SHIFT(0), .CNT_W(3)) dut_ns (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ns_in_ready), .instr(instr),
    .out_valid(ns_out_valid), .out_ready(out_ready), .instr_out(ns_instr_out),
    .alu_ctrl(ns_alu_ctrl), .rd(ns_rd), .rs1(ns_rs1), .rs2(ns_rs2), .imm(ns_imm),
    .reg_write(ns_reg_write), .alu_src_imm(ns_alu_src_imm), .mem_read(ns_mem_read),
    .mem_write(ns_mem_write), .branch(ns_branch), .illegal(ns_illegal),
    .illegal_count(ns_illegal_count)
  );

  // Expected bundle; flags = {reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}.
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [5:0]  flags;
  } exp_t;

  typedef enum int { F_NONE, F_I, F_S, F_B } fmt_e;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  alu;
    fmt_e        fmt;
    logic [4:0]  ctl;    // {reg_write, alu_src_imm, mem_read, mem_write, branch}
    bit          shift;  // only legal when shift/compare/xor support is built in
  } ent_t;

  localparam int NENT = 20;
  ent_t tbl [NENT];

  localparam logic [31:0] M_R  = 32'hFE00707F;
  localparam logic [31:0] M_F3 = 32'h0000707F;

  initial begin
    tbl[0]  = '{M_R,  32'h00000033, 4'b0010, F_NONE, 5'b10000, 1'b0}; // ADD
    tbl[1]  = '{M_R,  32'h40000033, 4'b0110, F_NONE, 5'b10000, 1'b0}; // SUB
    tbl[2]  = '{M_R,  32'h00007033, 4'b0000, F_NONE, 5'b10000, 1'b0}; // AND
    tbl[3]  = '{M_R,  32'h00006033, 4'b0001, F_NONE, 5'b10000, 1'b0}; // OR
    tbl[4]  = '{M_R,  32'h00004033, 4'b0011, F_NONE, 5'b10000, 1'b1}; // XOR
    tbl[5]  = '{M_R,  32'h00001033, 4'b0100, F_NONE, 5'b10000, 1'b1}; // SLL
    tbl[6]  = '{M_R,  32'h00005033, 4'b0101, F_NONE, 5'b10000, 1'b1}; // SRL
    tbl[7]  = '{M_R,  32'h40005033, 4'b0111, F_NONE, 5'b10000, 1'b1}; // SRA
    tbl[8]  = '{M_R,  32'h00002033, 4'b1011, F_NONE, 5'b10000, 1'b1}; // SLT
    tbl[9]  = '{M_R,  32'h00003033, 4'b1100, F_NONE, 5'b10000, 1'b1}; // SLTU
    tbl[10] = '{M_F3, 32'h00000013, 4'b1010, F_I,    5'b11000, 1'b0}; // ADDI
    tbl[11] = '{M_F3, 32'h00007013, 4'b1000, F_I,    5'b11000, 1'b0}; // ANDI
    tbl[12] = '{M_F3, 32'h00006013, 4'b1001, F_I,    5'b11000, 1'b0}; // ORI
    tbl[13] = '{M_F3, 32'h00004013, 4'b1101, F_I,    5'b11000, 1'b1}; // XORI
    tbl[14] = '{M_R,  32'h00001013, 4'b1110, F_I,    5'b11000, 1'b1}; // SLLI
    tbl[15] = '{M_R,  32'h00005013, 4'b1111, F_I,    5'b11000, 1'b1}; // SRLI
    tbl[16] = '{M_R,  32'h40005013, 4'b1111, F_I,    5'b11000, 1'b1}; // SRAI
    tbl[17] = '{M_F3, 32'h00002003, 4'b0010, F_I,    5'b11100, 1'b0}; // LW
    tbl[18] = '{M_F3, 32'h00002023, 4'b0010, F_S,    5'b01010, 1'b0}; // SW
    tbl[19] = '{M_F3, 32'h00000063, 4'b0110, F_B,    5'b00001, 1'b0}; // BEQ
  end

  function automatic exp_t decode_model(input logic [31:0] w, input bit en_shift);
    exp_t e;
    e       = '0;
    e.instr = w;
    e.rd    = w[11:7];
    e.rs1   = w[19:15];
    e.rs2   = w[24:20];
    e.flags = 6'b000001;
    for (int i = 0; i < NENT; i++) begin
      if (((w & tbl[i].mask) == tbl[i].match) && (en_shift || !tbl[i].shift)) begin
        e.alu   = tbl[i].alu;
        e.flags = {tbl[i].ctl, 1'b0};
        case (tbl[i].fmt)
          F_I:     e.imm = 32'($signed(w[31:20]));
          F_S:     e.imm = 32'($signed({w[31:25], w[11:7]}));
          F_B:     e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          default: e.imm = 32'd0;
        endcase
      end
    end
    return e;
  endfunction

  function automatic bit model_illegal(input logic [31:0] w, input bit en_shift);
    exp_t e;
    e = decode_model(w, en_shift);
    return e.flags[0];
  endfunction

  // Cycle model: one-deep pipeline register with handshake and saturating counters.
  logic        m_valid;
  exp_t        m_b, m_bn;
  logic [15:0] m_cnt;
  logic [2:0]  m_cnt_ns;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_b      <= '0;
      m_bn     <= '0;
      m_cnt    <= '0;
      m_cnt_ns <= '0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_b     <= decode_model(instr, 1'b1);
      m_bn    <= decode_model(instr, 1'b0);
      if (model_illegal(instr, 1'b1) && m_cnt < 16'd65535) m_cnt <= m_cnt + 16'd1;
      if (model_illegal(instr, 1'b0) && m_cnt_ns < 3'd7)   m_cnt_ns <= m_cnt_ns + 3'd1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    check("instr_alu_regs", 64'({instr_out, alu_ctrl, rd, rs1, rs2}),
          64'({m_b.instr, m_b.alu, m_b.rd, m_b.rs1, m_b.rs2}));
    check("imm", 64'(imm), 64'(m_b.imm));
    check("flags", 64'({reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}), 64'(m_b.flags));
    check("illegal_count", 64'(illegal_count), 64'(m_cnt));
    check("ns_handshake", 64'({ns_out_valid, ns_in_ready}), 64'({m_valid, !m_valid || out_ready}));
    check("ns_instr_alu_regs", 64'({ns_instr_out, ns_alu_ctrl, ns_rd, ns_rs1, ns_rs2}),
          64'({m_bn.instr, m_bn.alu, m_bn.rd, m_bn.rs1, m_bn.rs2}));
    check("ns_imm", 64'(ns_imm), 64'(m_bn.imm));
    check("ns_flags", 64'({ns_reg_write, ns_alu_src_imm, ns_mem_read, ns_mem_write, ns_branch, ns_illegal}),
          64'(m_bn.flags));
    check("ns_illegal_count", 64'(ns_illegal_count), 64'(m_cnt_ns));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    tick();
  endtask

  logic [31:0] sweep [20] = '{
    32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h002091B3, 32'h0020D1B3,
    32'h4020D1B3, 32'h0020A1B3, 32'h0020B1B3, 32'h4020F1B3, 32'h0050F193,
    32'h8000F193, 32'h0050E193, 32'h0050C193, 32'h0050D193, 32'h4050D193,
    32'h0050A193, 32'h40509193, 32'h00C0A183, 32'h00C08183, 32'hFE209EE3
  };

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0;
    tick(); tick();
    check("rst_valid_ready", 64'({out_valid, in_ready}), 64'b01);
    check("rst_bundle", 64'({alu_ctrl, imm, illegal_count}), 64'd0);
    reset = 1'b0;

    send(32'h002081B3);
    check("add_alu", 64'(alu_ctrl), 64'b0010);
    check("add_regs", 64'({rd, rs1, rs2}), 64'({5'd3, 5'd1, 5'd2}));
    check("add_flags", 64'({out_valid, reg_write, alu_src_imm}), 64'b110);

    send(32'h402081B3);
    check("sub_alu", 64'(alu_ctrl), 64'b0110);
    send(32'hFFF00293);
    check("addi_alu_imm_rd", 64'({alu_ctrl, imm, rd}), 64'({4'b1010, 32'hFFFFFFFF, 5'd5}));
    send(32'h0020A423);
    check("sw_alu_imm_mw", 64'({alu_ctrl, imm, mem_write}), 64'({4'b0010, 32'd8, 1'b1}));

    send(32'hFE208EE3);
    check("beq_alu_imm", 64'({alu_ctrl, imm}), 64'({4'b0110, 32'hFFFFFFFC}));
    check("beq_flags", 64'({branch, reg_write}), 64'b10);

    send(32'hFFFFFFFF);
    check("ill1_flags", 64'({reg_write, alu_src_imm, mem_read, mem_write, branch, illegal}), 64'b000001);
    send(32'h022081B3);
    check("ill2_flags", 64'({alu_ctrl, imm, reg_write, branch, illegal}), 64'd1);
    check("ill_count2", 64'(illegal_count), 64'd2);
    in_valid = 1'b0;
    tick();
    check("drain", 64'(out_valid), 64'd0);

    send(32'h00209193);
    check("slli_en", 64'({alu_ctrl, imm[4:0], illegal}), 64'({4'b1110, 5'd2, 1'b0}));
    check("slli_noshift", 64'({ns_illegal, ns_alu_ctrl}), 64'({1'b1, 4'b0000}));
    out_ready = 1'b0;
    instr     = 32'h002081B3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", 64'({in_ready, out_valid, instr_out, alu_ctrl}),
            64'({1'b0, 1'b1, 32'h00209193, 4'b1110}));
    end
    out_ready = 1'b1;
    tick();
    check("release_next", 64'({out_valid, instr_out, alu_ctrl}), 64'({1'b1, 32'h002081B3, 4'b0010}));

    out_ready = 1'b0;
    instr     = 32'hFFF00293;
    tick();
    reset = 1'b1;
    tick();
    check("stall_reset", 64'({out_valid, in_ready, instr_out, alu_ctrl, illegal_count}), 64'({1'b0, 1'b1, 52'd0}));
    check("stall_reset_imm", 64'({imm, reg_write, illegal}), 64'd0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) send(32'hFFFFFFFF);
    check("sat_counts", 64'({illegal_count, ns_illegal_count}), 64'({16'd10, 3'd7}));
    send(32'h123451B7);
    check("sat_hold", 64'({illegal_count, ns_illegal_count}), 64'({16'd11, 3'd7}));

    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 3 != 2);
      send(sweep[i]);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, handshaked RV32I decode stage; successor to the combinational ALU-control decoder.
- Takes one 32-bit instruction per in_valid/in_ready handshake.
- Presents one cycle later: ALU control code, register indices, sign-extended immediate, datapath control flags and an illegal-instruction flag.
- Sits between instruction fetch and register-file/execute; also keeps a saturating count of illegal instructions.

Parameters:
- XLEN, 32, width of instruction and immediate datapath (only 32 supported).
- EN_SHIFT, 1, when 1 decode SLL/SRL/SRA/SLLI/SRLI/SRAI/SLT/SLTU/XOR/XORI; when 0 these are illegal.
- CNT_W, 16, width of illegal_count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- instr  in  XLEN  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- instr_out  out  XLEN  copy of accepted instruction.
- alu_ctrl  out  4  ALU operation code.
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20].
- imm  out  XLEN  sign-extended immediate (I/S/B format).
- reg_write, alu_src_imm, mem_read, mem_write, branch  out  1 each  datapath controls.
- illegal  out  1  unsupported encoding.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (synchronous, active-high, clk edge): out_valid=0; every bundle output, including instr_out, =0; illegal_count=0. Reset overrides any handshake in the same cycle, so an in-flight or stalled bundle is dropped.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, bundle registers load the next cycle: latency 1, throughput 1 per cycle.
- No accept and out_ready=1: out_valid clears.
- out_valid=1 and out_ready=0: all outputs hold stable; in_ready=0.
- ALU codes (retained): AND 0000, OR 0001, ADD 0010, SUB 0110, ANDI 1000, ORI 1001, ADDI 1010.
- ALU codes (new): XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1011, SLTU 1100, XORI 1101, SLLI 1110, SRLI/SRAI 1111 (instr[30] selects arithmetic in ALU).
- R-type (opcode 0110011): funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA). reg_write=1, alu_src_imm=0.
- I-type ALU (0010011): ADDI/ANDI/ORI always; others per EN_SHIFT. Shift funct7 must be 0000000, or 0100000 for SRAI. reg_write=1, alu_src_imm=1, imm=I-format.
- LW (0000011, funct3 010): ADD, mem_read=1, reg_write=1, alu_src_imm=1.
- SW (0100011, funct3 010): ADD, mem_write=1, alu_src_imm=1, imm=S-format.
- BEQ (1100011, funct3 000): SUB, branch=1, imm=B-format (bit0=0).
- Anything else is illegal: illegal=1, alu_ctrl=0000, all control flags 0, imm=0. rd/rs1/rs2/instr_out still reflect the bits.
- illegal_count increments on accept of an illegal instruction; it saturates at all-ones and never wraps.

Test Plan:
- Reset, then instr 0x002081B3 (ADD x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, rd=3, rs1=1, rs2=2, reg_write=1, alu_src_imm=0.
- Back-to-back: 0x402081B3, 0xFFF00293, 0x0020A423 -> three consecutive outputs: SUB 0110; ADDI 1010 with imm=0xFFFFFFFF, rd=5; ADD 0010 with mem_write=1, imm=8.
- 0xFE208EE3 (BEQ x1,x2,-4) -> alu_ctrl=0110, branch=1, imm=0xFFFFFFFC, reg_write=0.
- 0xFFFFFFFF, then 0x002081B3 with funct7 forced to 0000001 -> both illegal=1 with all flags 0; illegal_count=2. Preload via long run of illegals -> count holds at all-ones.
- out_ready=0 with a valid bundle, in_valid=1 for 3 cycles -> in_ready=0 and outputs unchanged. Raise out_ready -> held bundle retires and the next instruction is accepted the same cycle.
- Assert reset while stalled -> next cycle out_valid=0, outputs 0, illegal_count=0, in_ready=1.
- EN_SHIFT=0 build: 0x00209193 (SLLI) -> illegal=1. EN_SHIFT=1 build: same instruction -> alu_ctrl=1110, imm[4:0]=2.
